// File: rtl/nn_demo_pkg.sv
// Shared constants for the neural-network demo run controller.
//  - Controller state encoding (IDLE, RUN, SHOW, ERR).
//  - Active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}.
//  - 16-entry hex digit to segment table.
package nn_demo_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_SHOW = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;

   // Entry n is the pattern for hex digit n (entry 15 is the leftmost element).
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,   // F E d C
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,   // b A 9 8
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,   // 7 6 5 4
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000    // 3 2 1 0
   };

endpackage

// File: rtl/nn_demo_controller_seg7_hex_decoder.sv
// Combinational hex digit to active-low 7-segment decoder.
//  value : 4-bit digit value 0..15
//  blank : forces all segments off
//  seg   : active-low segments {g,f,e,d,c,b,a}
module seg7_hex_decoder
   import nn_demo_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_BLANK : HEX_SEG_TABLE[value];

endmodule

// File: rtl/nn_demo_controller.sv
// Board-level run controller for the neural-network FPGA demo.
// Debounces the start key, pulses nn_start, times the inference with a
// saturating latency counter, latches the argmax class, reports a hung core
// through a watchdog, and drives 7-segment digits and status LEDs.
//  clk, reset    : clock, asynchronous active-high reset
//  key_n         : raw active-low start key (asynchronous)
//  nn_done       : core completion, honoured only while running
//  nn_argmax     : core result class, latched on accepted nn_done
//  nn_state      : core FSM state, mirrored on ledr[5:0]
//  nn_start      : single-cycle start pulse to the core
//  busy          : high while running
//  result_valid  : high while a result is shown
//  hex           : digit d at [7d+6:7d], active-low {g,f,e,d,c,b,a}
//  ledr          : {key pressed, busy, result_valid, error, nn_state}
module nn_demo_controller
   import nn_demo_pkg::*;
#(
   parameter int CLASS_W         = 4,
   parameter int NUM_CLASSES     = 10,
   parameter int NUM_DIGITS      = 5,
   parameter int LAT_W           = 16,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 65535,
   parameter int STATE_W         = 4
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    key_n,
   input  logic                    nn_done,
   input  logic [CLASS_W-1:0]      nn_argmax,
   input  logic [STATE_W-1:0]      nn_state,
   output logic                    nn_start,
   output logic                    busy,
   output logic                    result_valid,
   output logic [7*NUM_DIGITS-1:0] hex,
   output logic [9:0]              ledr
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int NIB_W = 4 * (NUM_DIGITS - 1);

   logic              key_sync1, key_sync2, key_level, key_level_next;
   logic              key_accept, press;
   logic [DB_W-1:0]   db_cnt;
   logic [1:0]        state, state_next;
   logic              start_now;
   logic [LAT_W-1:0]  lat_cnt, res_lat;
   logic [CLASS_W-1:0] res_class;
   logic              class_ok;
   logic [NIB_W-1:0]  lat_nib;
   logic [7*NUM_DIGITS-1:0] hex_next;

   // Key synchroniser; idles released (high) so reset never looks like a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_sync1 <= 1'b1;
         key_sync2 <= 1'b1;
      end else begin
         key_sync1 <= key_n;
         key_sync2 <= key_sync1;
      end
   end

   // db_cnt counts consecutive samples that disagree with the accepted level;
   // any agreeing sample restarts the run, so glitches are discarded.
   assign key_accept     = (key_sync2 != key_level) &&
                           (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
   assign key_level_next = key_accept ? key_sync2 : key_level;
   assign press          = key_accept && !key_sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_level <= 1'b1;
         db_cnt    <= '0;
      end else begin
         key_level <= key_level_next;
         if (key_sync2 == key_level || key_accept)
            db_cnt <= '0;
         else
            db_cnt <= db_cnt + DB_W'(1);
      end
   end

   // nn_done has priority over the watchdog on the same cycle.
   always_comb begin
      state_next = state;
      start_now  = 1'b0;
      case (state)
         ST_RUN: begin
            if (nn_done)
               state_next = ST_SHOW;
            else if (lat_cnt == LAT_W'(TIMEOUT_CYCLES))
               state_next = ST_ERR;
         end
         default: begin
            if (press) begin
               state_next = ST_RUN;
               start_now  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         nn_start     <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         ledr         <= '0;
      end else begin
         state        <= state_next;
         nn_start     <= start_now;
         busy         <= (state_next == ST_RUN);
         result_valid <= (state_next == ST_SHOW);
         ledr         <= {~key_level_next, state_next == ST_RUN,
                          state_next == ST_SHOW, state_next == ST_ERR,
                          6'(nn_state)};
      end
   end

   // lat_cnt reads 1 in the first RUN cycle, so it equals the RUN cycle index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_cnt   <= '0;
         res_lat   <= '0;
         res_class <= '0;
      end else if (start_now) begin
         lat_cnt   <= LAT_W'(1);
         res_lat   <= '0;
         res_class <= '0;
      end else if (state == ST_RUN) begin
         if (lat_cnt != '1)
            lat_cnt <= lat_cnt + LAT_W'(1);
         if (nn_done) begin
            res_lat   <= lat_cnt;
            res_class <= nn_argmax;
         end
      end
   end

   assign class_ok = (32'(res_class) < 32'(NUM_CLASSES));
   assign lat_nib  = NIB_W'(res_lat);

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
      logic [3:0] value;
      logic       blank;
      logic [6:0] seg;

      if (d == 0) begin : g_class
         assign value = 4'(res_class);
         assign blank = 1'b0;
         assign hex_next[6:0] = (state == ST_SHOW) ? (class_ok ? seg : SEG_E) :
                                (state == ST_ERR)  ? SEG_E : SEG_DASH;
      end else begin : g_latency
         assign value = lat_nib[4*(d-1) +: 4];
         // Nibbles lying wholly above the latency width carry no information.
         assign blank = (4 * (d - 1) >= LAT_W);
         assign hex_next[7*d +: 7] = (state == ST_SHOW) ? seg : SEG_BLANK;
      end

      seg7_hex_decoder u_dec (
         .value (value),
         .blank (blank),
         .seg   (seg)
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hex <= '1;
      else
         hex <= hex_next;
   end

endmodule
